// File: rtl/button_events.sv
// button_events: per-button press classifier for four debounced, active-high
// button levels. Each channel turns a press into exactly one event pulse:
// short_pulse on a release before LONG_CYCLES high samples, long_pulse when
// the hold reaches LONG_CYCLES, and optionally repeat_pulse every
// REPEAT_CYCLES samples while a long press stays held.
//
// Optional feature macro: BUTTON_EVENTS_AUTO_REPEAT_EN
//   defined     -> repeat counters and repeat_pulse generation compiled in
//   not defined -> repeat_pulse tied to 4'b0000; LONG only waits for release
//
// All outputs are registered. Reset is synchronous and active-low.

module button_events #(
    parameter int LONG_CYCLES   = 6000000,
    parameter int REPEAT_CYCLES = 1200000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [3:0] btn_state,
    output logic [3:0] short_pulse,
    output logic [3:0] long_pulse,
    output logic [3:0] repeat_pulse,
    output logic [3:0] held
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    localparam logic [23:0] LONG_C = 24'(LONG_CYCLES);

`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
    localparam logic [23:0] REPEAT_C = 24'(REPEAT_CYCLES);
`else
    // The repeat period only matters when auto-repeat is compiled in.
    logic w_unused_repeat;
    assign w_unused_repeat = ^(24'(REPEAT_CYCLES));
    assign repeat_pulse    = 4'b0000;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_chan
        state_t      r_state;
        state_t      w_state_nxt;
        logic [23:0] r_cnt;
        logic [23:0] w_cnt_nxt;
        logic        r_prev;
        logic        w_btn;
        logic        r_short;
        logic        r_long;
        logic        r_held;
        logic        w_short_nxt;
        logic        w_long_nxt;
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
        logic [23:0] r_rcnt;
        logic [23:0] w_rcnt_nxt;
        logic        r_repeat;
        logic        w_repeat_nxt;
`endif

        assign w_btn = btn_state[g];

        // Next-state, counter and event decode for this channel.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_short_nxt = 1'b0;
            w_long_nxt  = 1'b0;
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
            w_rcnt_nxt   = r_rcnt;
            w_repeat_nxt = 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    // Only a low-to-high transition starts a press; a level
                    // already high since reset is ignored.
                    if (w_btn && !r_prev) begin
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = 24'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (w_btn) begin
                        // >= keeps cnt saturated at the threshold.
                        if ((r_cnt + 24'd1) >= LONG_C) begin
                            w_state_nxt = ST_LONG;
                            w_cnt_nxt   = LONG_C;
                            w_long_nxt  = 1'b1;
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
                            w_rcnt_nxt  = 24'd0;
`endif
                        end else begin
                            w_cnt_nxt   = r_cnt + 24'd1;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 24'd0;
                        w_short_nxt = 1'b1;
                    end
                end
                ST_LONG: begin
                    if (w_btn) begin
                        w_state_nxt = ST_LONG;
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
                        if ((r_rcnt + 24'd1) >= REPEAT_C) begin
                            w_rcnt_nxt   = 24'd0;
                            w_repeat_nxt = 1'b1;
                        end else begin
                            w_rcnt_nxt   = r_rcnt + 24'd1;
                        end
`endif
                    end else begin
                        // Release after a long press produces no event.
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 24'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 24'd0;
                end
            endcase
        end

        // State, counters, previous sample and registered outputs.
        always_ff @(posedge CLK) begin
            if (!RESETN) begin
                r_state  <= ST_IDLE;
                r_cnt    <= 24'd0;
                r_prev   <= 1'b1;
                r_short  <= 1'b0;
                r_long   <= 1'b0;
                r_held   <= 1'b0;
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
                r_rcnt   <= 24'd0;
                r_repeat <= 1'b0;
`endif
            end else begin
                r_state  <= w_state_nxt;
                r_cnt    <= w_cnt_nxt;
                r_prev   <= w_btn;
                r_short  <= w_short_nxt;
                r_long   <= w_long_nxt;
                r_held   <= (w_state_nxt != ST_IDLE);
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
                r_rcnt   <= w_rcnt_nxt;
                r_repeat <= w_repeat_nxt;
`endif
            end
        end

        assign short_pulse[g] = r_short;
        assign long_pulse[g]  = r_long;
        assign held[g]        = r_held;
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
        assign repeat_pulse[g] = r_repeat;
`endif
    end

endmodule

// File: tb/tb_button_events.sv
// Directed testbench for button_events with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Inputs change on the falling edge; outputs are checked on the next falling
// edge, i.e. half a cycle after the rising edge that sampled the input.

module tb_button_events;

    logic       CLK;
    logic       RESETN;
    logic [3:0] btn_state;
    logic [3:0] short_pulse;
    logic [3:0] long_pulse;
    logic [3:0] repeat_pulse;
    logic [3:0] held;

    int n_assert = 0;
    int n_fail   = 0;
    logic [3:0] rep_mask;

    button_events #(
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .btn_state   (btn_state),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse),
        .held        (held)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] es, input logic [3:0] el,
                           input logic [3:0] er, input logic [3:0] eh);
        chk($sformatf("%s.short", tag),  short_pulse,  es);
        chk($sformatf("%s.long", tag),   long_pulse,   el);
        chk($sformatf("%s.repeat", tag), repeat_pulse, er);
        chk($sformatf("%s.held", tag),   held,         eh);
    endtask

    task automatic step(input logic [3:0] b);
        btn_state = b;
        @(negedge CLK);
    endtask

    initial begin
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
        rep_mask = 4'b1111;
`else
        rep_mask = 4'b0000;
`endif
        RESETN    = 1'b0;
        btn_state = 4'b0000;
        @(negedge CLK);
        @(negedge CLK);
        chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        RESETN = 1'b1;
        step(4'b0000);
        chk_all("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Short press: 3 high samples then release.
        for (int s = 1; s <= 3; s++) begin
            step(4'b0001);
            chk_all($sformatf("short3_s%0d", s), 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        end
        step(4'b0000);
        chk_all("short3_rel", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000);
        chk_all("short3_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Threshold minus one: 7 samples gives a short press.
        for (int s = 1; s <= 7; s++) begin
            step(4'b0001);
            chk_all($sformatf("hold7_s%0d", s), 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        end
        step(4'b0000);
        chk_all("hold7_rel", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000);
        chk_all("hold7_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Exactly at threshold: long pulse after the 8th sample, silent release.
        for (int s = 1; s <= 8; s++) begin
            step(4'b0001);
            chk_all($sformatf("hold8_s%0d", s), 4'b0000,
                    (s == 8) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0001);
        end
        step(4'b0000);
        chk_all("hold8_rel", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000);

        // Channel 1 held 20 samples: long at 8, repeats at 12/16/20 if enabled.
        for (int s = 1; s <= 20; s++) begin
            step(4'b0010);
            chk_all($sformatf("hold20_s%0d", s), 4'b0000,
                    (s == 8) ? 4'b0010 : 4'b0000,
                    ((s == 12 || s == 16 || s == 20) ? 4'b0010 : 4'b0000) & rep_mask,
                    4'b0010);
        end
        step(4'b0000);
        chk_all("hold20_rel", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000);

        // Reset asserted at sample 5 of a press.
        for (int s = 1; s <= 4; s++) begin
            step(4'b0001);
            chk_all($sformatf("rstpress_s%0d", s), 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        end
        RESETN = 1'b0;
        step(4'b0001);
        chk_all("rst_mid", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        RESETN = 1'b1;
        // Button still high after reset: ignored, even past the long threshold.
        for (int s = 1; s <= 10; s++) begin
            step(4'b0001);
            chk_all($sformatf("rst_stuck_s%0d", s), 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        step(4'b0000);
        chk_all("rst_stuck_rel", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int s = 1; s <= 3; s++) begin
            step(4'b0001);
            chk_all($sformatf("repress_s%0d", s), 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        end
        step(4'b0000);
        chk_all("repress_rel", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000);

        // Concurrency: ch0/ch3 short (2 samples), ch2 held 10 samples.
        for (int s = 1; s <= 10; s++) begin
            logic [3:0] b;
            logic [3:0] eh;
            b  = {(s <= 2), 1'b1, 1'b0, (s <= 2)};
            eh = (s <= 2) ? 4'b1101 : 4'b0100;
            step(b);
            chk_all($sformatf("conc_s%0d", s), (s == 3) ? 4'b1001 : 4'b0000,
                    (s == 8) ? 4'b0100 : 4'b0000, 4'b0000, eh);
        end
        step(4'b0000);
        chk_all("conc_rel", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000);
        chk_all("conc_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/button_events.md
# button_events

Per-button press classifier downstream of the 4-channel debouncer. It consumes the debounced, active-high button levels and turns each press into a one-cycle event pulse. A release before the long-press threshold gives a short press; holding to the threshold gives a long press. An optional auto-repeat stream is emitted while a long press is held. Outputs drive the LED/menu logic directly; all four channels are independent.

## Interface

Parameters:
- `LONG_CYCLES`, default 6000000: high samples that make a long press (0.5 s at 12 MHz). Range 2 … 2^24−1.
- `REPEAT_CYCLES`, default 1200000: high samples between auto-repeat pulses (100 ms). Range 2 … 2^24−1.

Ports:
- `CLK` input 1: single system clock. All logic is on its rising edge.
- `RESETN` input 1: reset, synchronous and active-low.
- `btn_state` input 4: debounced levels, 1 = pressed. Synchronous to `CLK`; no further synchronisation is done here.
- `short_pulse` output 4: one-cycle pulse per short press.
- `long_pulse` output 4: one-cycle pulse when the long threshold is reached.
- `repeat_pulse` output 4: one-cycle auto-repeat pulses (see Configuration).
- `held` output 4: level, 1 while the channel is in HELD or LONG.

## Operation

- Each channel has its own FSM, a 24-bit hold counter `cnt`, a 24-bit repeat counter `rcnt`, and a previous-sample bit `prev`.
- Hold length L is the number of consecutive rising edges at which `btn_state[i]` was sampled 1.
- **IDLE**:
  - `btn_state[i]=1` and `prev[i]=0` → go to HELD with `cnt` = 1.
  - A high level with `prev[i]=1` is not a press. This only occurs after reset and is ignored.
- **HELD**:
  - Sample 1 → `cnt`+1.
  - If `cnt`+1 == `LONG_CYCLES` → go to LONG, pulse `long_pulse[i]`, clear `rcnt`.
  - Sample 0 → go to IDLE and pulse `short_pulse[i]`. This path is only reachable with L < `LONG_CYCLES`.
- **LONG**:
  - Sample 1 → stay. With `AUTO_REPEAT_EN`, `rcnt`+1; when it reaches `REPEAT_CYCLES`, pulse `repeat_pulse[i]` and clear `rcnt`.
  - Sample 0 → go to IDLE with no pulse.
- Counters saturate rather than wrap. `cnt` cannot exceed `LONG_CYCLES`, and `rcnt` cannot exceed `REPEAT_CYCLES`.
- At most one of short/long/repeat is asserted per channel per cycle. Different channels may pulse in the same cycle.
- `prev[i]` is updated with `btn_state[i]` every cycle, in every state.

## Timing

- Every output is registered. All outputs reset to 0.
- Reset values:
  - FSMs go to IDLE; `cnt` and `rcnt` go to 0.
  - `prev` goes to 4'b1111. As a result, a button held through reset release produces no event until it has been sampled low and pressed again.
- Latencies, with edge k as the first high sample:
  - `held[i]` rises after edge k.
  - `long_pulse[i]` is high for the cycle following edge k+`LONG_CYCLES`−1 (the `LONG_CYCLES`-th high sample).
  - `short_pulse[i]` is high for the cycle following the first low sample.
  - `held[i]` falls after that same first low sample.
- Auto-repeat timing: the n-th `repeat_pulse[i]` follows high sample number `LONG_CYCLES` + n·`REPEAT_CYCLES`.
- Reset mid-press:
  - No pulse is emitted in the reset cycle.
  - Any pending short/long/repeat event is discarded.
- Glitch of one low sample: the debouncer guarantees this never happens. If it does, it is treated as a real release followed by a new press.

## Configuration

- `BUTTON_EVENTS_AUTO_REPEAT_EN` defined:
  - The `rcnt` counters and repeat logic are compiled in.
  - `repeat_pulse` behaves as described above.
- Not defined:
  - The `rcnt` counters and repeat logic are removed.
  - `repeat_pulse` is tied to 4'b0000.
  - LONG only waits for release.
  - All other behaviour is identical.

## Test plan

Parameters `LONG_CYCLES`=8, `REPEAT_CYCLES`=4 unless noted.

- Short press: `btn_state[0]` high for 3 samples, then low → `short_pulse` = 4'b0001 for exactly 1 cycle, one cycle after the first low sample. `held[0]` is high for 3 cycles. No long pulse.
- Threshold edge: held 7 samples → short pulse only. Held exactly 8 samples → `long_pulse[0]` after the 8th sample, and no short pulse on release.
- Auto-repeat, with the macro defined: `btn_state[1]` held 20 samples → `long_pulse[1]` after sample 8, `repeat_pulse[1]` after samples 12, 16 and 20. Without the macro: the long pulse only, `repeat_pulse` constantly 0.
- Reset:
  - `RESETN` low at sample 5 of a press → all outputs 0 the next cycle, no pulse ever for that press.
  - Button still high after reset release → no events until it is seen low, then a 3-sample re-press → one short pulse.
- Concurrency: channels 0 and 3 pressed on the same edge, both released after 2 samples → `short_pulse` = 4'b1001 in a single cycle. Meanwhile channel 2 held 10 samples → a single `long_pulse[2]`, unaffected by the other channels.
